// File: rtl/rx_capture_ring.sv
// rx_capture_ring
//
// Circular capture buffer for the RX sample path. Samples stream into a
// DEPTH-entry ring while armed. A trigger starts a post-trigger count of
// POST_LEN further samples, after which the ring freezes. The frozen
// window is then read back oldest-first by relative index.
//
// Parameters
//   DATA_W    sample width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   POST_LEN  samples written after the trigger sample (0 .. DEPTH-1)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   arm       pulse: clear pointers/counters and start capturing (any state)
//   trig      pulse: trigger event, honoured only while ARMED
//   wr_en     sample strobe
//   wr_data   sample value
//   rd_en     read request, honoured only while FROZEN
//   rd_idx    relative read index, 0 = oldest sample in the window
//   rd_data   read data, valid when rd_valid = 1, held otherwise
//   rd_valid  pulses one cycle after an honoured rd_en
//   frozen    window complete and readable
//   fill      samples held in the window, saturates at DEPTH
//   trig_pos  relative index of the trigger sample, valid while frozen
//   dropped   sticky: wr_en seen while IDLE or FROZEN, cleared by arm

module rx_capture_ring #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 10,
    parameter int POST_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frozen,
    output logic [ADDR_W:0]   fill,
    output logic [ADDR_W-1:0] trig_pos,
    output logic              dropped
);

    localparam int DEPTH = 2 ** ADDR_W;

    // fill is one bit wider than the address so it can hold DEPTH itself
    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   POST_F   = (ADDR_W + 1)'(POST_LEN);
    localparam logic [ADDR_W-1:0] POST_C   = ADDR_W'(POST_LEN);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam bit                NO_POST  = (POST_LEN == 0);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        FROZEN
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_cnt;

    // Sample storage; deliberately not reset so it can map onto block RAM
    logic [DATA_W-1:0] ram [DEPTH];

    logic              capturing;
    logic              ram_we;
    logic              fill_full;
    logic [ADDR_W:0]   fill_next;
    logic              trig_ok;
    logic              post_done;
    logic              freeze_now;
    logic [ADDR_W:0]   trig_pos_wide;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ok;

    // Decode of this cycle's actions. arm overrides every other input, so
    // each qualifier below is gated by !arm.
    always_comb begin
        capturing = (state == ARMED) || (state == POST);
        ram_we    = !arm && wr_en && capturing;
        fill_full = (fill == FILL_MAX);

        fill_next = fill;
        if (ram_we && !fill_full) begin
            fill_next = fill + FILL_ONE;
        end

        // With no write this cycle the trigger refers to the last sample
        // already stored, which only exists if something has been written.
        trig_ok = !arm && trig && (state == ARMED) && (wr_en || (fill != '0));

        post_done  = (state == POST) && ram_we && ((post_cnt + CNT_ONE) == POST_C);
        freeze_now = post_done || (trig_ok && NO_POST);

        // Trigger sample sits POST_LEN entries before the newest one; the
        // result is taken modulo the address width.
        trig_pos_wide = fill_next - FILL_ONE - POST_F;

        // Once the ring has wrapped, the oldest sample lives at wr_ptr.
        rd_base = fill_full ? wr_ptr : '0;
        rd_addr = rd_base + rd_idx;
        rd_ok   = !arm && rd_en && (state == FROZEN);
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    // Capture FSM with registered status and read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            post_cnt <= '0;
            fill     <= '0;
            frozen   <= 1'b0;
            trig_pos <= '0;
            dropped  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            if (rd_ok) begin
                rd_data  <= ram[rd_addr];
                rd_valid <= 1'b1;
            end

            if (arm) begin
                state    <= ARMED;
                wr_ptr   <= '0;
                post_cnt <= '0;
                fill     <= '0;
                frozen   <= 1'b0;
                dropped  <= 1'b0;
            end else begin
                if (ram_we) begin
                    wr_ptr <= wr_ptr + CNT_ONE;
                    fill   <= fill_next;
                end

                case (state)
                    IDLE: begin
                        if (wr_en) begin
                            dropped <= 1'b1;
                        end
                    end

                    ARMED: begin
                        if (trig_ok) begin
                            post_cnt <= '0;
                            if (freeze_now) begin
                                state    <= FROZEN;
                                frozen   <= 1'b1;
                                trig_pos <= trig_pos_wide[ADDR_W-1:0];
                            end else begin
                                state <= POST;
                            end
                        end
                    end

                    POST: begin
                        if (ram_we) begin
                            post_cnt <= post_cnt + CNT_ONE;
                        end
                        if (freeze_now) begin
                            state    <= FROZEN;
                            frozen   <= 1'b1;
                            trig_pos <= trig_pos_wide[ADDR_W-1:0];
                        end
                    end

                    FROZEN: begin
                        if (wr_en) begin
                            dropped <= 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_capture_ring.sv
// tb_rx_capture_ring
//
// Bench for rx_capture_ring with a 16-entry ring. Two instances share the
// same stimulus: one with POST_LEN = 3 and one with POST_LEN = 0. Expected
// read data is queued when a read is issued and compared when rd_valid
// appears on the instance currently selected for checking.

module tb_rx_capture_ring;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              trig;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;

    logic [DATA_W-1:0] rd_data3,  rd_data0;
    logic              rd_valid3, rd_valid0;
    logic              frozen3,   frozen0;
    logic [ADDR_W:0]   fill3,     fill0;
    logic [ADDR_W-1:0] trig_pos3, trig_pos0;
    logic              dropped3,  dropped0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;
    bit                sel0 = 1'b0;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;

    always #5 clk = ~clk;

    rx_capture_ring #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .POST_LEN(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig     (trig),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data3),
        .rd_valid (rd_valid3),
        .frozen   (frozen3),
        .fill     (fill3),
        .trig_pos (trig_pos3),
        .dropped  (dropped3)
    );

    rx_capture_ring #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .POST_LEN(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig     (trig),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data0),
        .rd_valid (rd_valid0),
        .frozen   (frozen0),
        .fill     (fill0),
        .trig_pos (trig_pos0),
        .dropped  (dropped0)
    );

    assign sel_valid = sel0 ? rd_valid0 : rd_valid3;
    assign sel_data  = sel0 ? rd_data0  : rd_data3;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Read-data scoreboard: every rd_valid must match a queued expectation
    always @(posedge clk) begin
        #1;
        if (sel_valid === 1'b1) begin
            checkOutput("rd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("rd_data", 32'(sel_data), 32'(mon_exp));
            end
        end
    end

    // One clock of stimulus: drive at the falling edge, return just after
    // the rising edge so status outputs can be checked.
    task automatic applyStimulus(input logic a, input logic t, input logic w,
                                 input logic [DATA_W-1:0] d, input logic r,
                                 input logic [ADDR_W-1:0] idx,
                                 input bit expect_rd = 1'b0,
                                 input logic [DATA_W-1:0] exp_val = '0);
        @(negedge clk);
        if (r) begin
            // the previous read must already have been returned
            checkOutput("rd_lag", 32'(exp_q.size()), 32'd0);
        end
        if (expect_rd) begin
            exp_q.push_back(exp_val);
        end
        arm     = a;
        trig    = t;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        rd_idx  = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic writeSample(input logic [DATA_W-1:0] d, input logic t);
        applyStimulus(1'b0, t, 1'b1, d, 1'b0, '0);
    endtask

    task automatic readIdx(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] e);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, idx, 1'b1, e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic armRing();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; wr_en = 1'b0;
        wr_data = '0; rd_en = 1'b0; rd_idx = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rd_data",  32'(rd_data3),  32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid3), 32'd0);
        checkOutput("rst_frozen",   32'(frozen3),   32'd0);
        checkOutput("rst_fill",     32'(fill3),     32'd0);
        checkOutput("rst_trig_pos", 32'(trig_pos3), 32'd0);
        checkOutput("rst_dropped",  32'(dropped3),  32'd0);
        rst = 1'b0;

        // IDLE ignores writes (but flags them) and ignores trig
        writeSample(18'd5, 1'b0);
        checkOutput("idle_dropped", 32'(dropped3), 32'd1);
        checkOutput("idle_fill",    32'(fill3),    32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        checkOutput("idle_trig_frozen", 32'(frozen3), 32'd0);

        // Basic capture: 0..8, trigger on 5
        armRing();
        checkOutput("arm_dropped", 32'(dropped3), 32'd0);
        checkOutput("arm_fill",    32'(fill3),    32'd0);
        for (int i = 0; i < 9; i++) begin
            writeSample(DATA_W'(i), (i == 5));
            if (i == 7) checkOutput("t1_not_frozen", 32'(frozen3), 32'd0);
        end
        checkOutput("t1_frozen",   32'(frozen3),   32'd1);
        checkOutput("t1_fill",     32'(fill3),     32'd9);
        checkOutput("t1_trig_pos", 32'(trig_pos3), 32'd5);
        for (int i = 0; i < 9; i++) readIdx(ADDR_W'(i), DATA_W'(i));
        idleCycle();
        checkOutput("t1_drain", 32'(exp_q.size()), 32'd0);

        // arm right behind a read: the read still completes with old data
        readIdx(4'd2, 18'd2);
        armRing();
        checkOutput("arm_rd_valid_clr", 32'(rd_valid3), 32'd0);
        checkOutput("rearm_frozen",     32'(frozen3),   32'd0);
        checkOutput("rearm_fill",       32'(fill3),     32'd0);

        // Wrapped capture: 0..39, trigger on 36
        for (int i = 0; i < 40; i++) begin
            writeSample(DATA_W'(i), (i == 36));
            if (i == 38) checkOutput("t2_not_frozen", 32'(frozen3), 32'd0);
        end
        checkOutput("t2_frozen",   32'(frozen3),   32'd1);
        checkOutput("t2_fill",     32'(fill3),     32'd16);
        checkOutput("t2_trig_pos", 32'(trig_pos3), 32'd12);
        for (int i = 0; i < 16; i++) readIdx(ADDR_W'(i), DATA_W'(24 + i));

        // A write while frozen must not touch the oldest entry (ram[8])
        writeSample(18'd777, 1'b0);
        checkOutput("frz_dropped", 32'(dropped3), 32'd1);
        checkOutput("frz_fill",    32'(fill3),    32'd16);
        readIdx(4'd0,  18'd24);
        readIdx(4'd15, 18'd39);
        idleCycle();
        checkOutput("t2_drain", 32'(exp_q.size()), 32'd0);
        armRing();
        checkOutput("frz_arm_dropped", 32'(dropped3), 32'd0);
        checkOutput("frz_arm_frozen",  32'(frozen3),  32'd0);
        checkOutput("frz_arm_fill",    32'(fill3),    32'd0);

        // arm with trig and wr_en in the same cycle: just ARMED, no write
        applyStimulus(1'b1, 1'b1, 1'b1, 18'd50, 1'b0, '0);
        checkOutput("armtrig_fill", 32'(fill3), 32'd0);
        for (int i = 1; i <= 3; i++) writeSample(DATA_W'(i), 1'b0);
        checkOutput("armtrig_not_post", 32'(frozen3), 32'd0);
        checkOutput("armtrig_fill3",    32'(fill3),   32'd3);

        // trig with an empty window is ignored
        armRing();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 60; i <= 62; i++) writeSample(DATA_W'(i), 1'b0);
        checkOutput("trig_empty_ignored", 32'(frozen3), 32'd0);
        checkOutput("trig_empty_fill",    32'(fill3),   32'd3);
        for (int i = 63; i <= 66; i++) writeSample(DATA_W'(i), (i == 63));
        checkOutput("t3_frozen",   32'(frozen3),   32'd1);
        checkOutput("t3_fill",     32'(fill3),     32'd7);
        checkOutput("t3_trig_pos", 32'(trig_pos3), 32'd3);
        readIdx(4'd3, 18'd63);
        readIdx(4'd0, 18'd60);
        idleCycle();
        checkOutput("t3_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of the post-trigger phase
        armRing();
        for (int i = 0; i < 4; i++) writeSample(DATA_W'(i), (i == 2));
        checkOutput("t4_pre_fill",   32'(fill3),   32'd4);
        checkOutput("t4_pre_frozen", 32'(frozen3), 32'd0);
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 18'd4;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_fill",     32'(fill3),     32'd0);
        checkOutput("arst_frozen",   32'(frozen3),   32'd0);
        checkOutput("arst_rd_valid", 32'(rd_valid3), 32'd0);
        checkOutput("arst_rd_data",  32'(rd_data3),  32'd0);
        checkOutput("arst_trig_pos", 32'(trig_pos3), 32'd0);
        checkOutput("arst_dropped",  32'(dropped3),  32'd0);
        @(negedge clk);
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) writeSample(DATA_W'(i), 1'b0);
        checkOutput("post_rst_frozen",  32'(frozen3),  32'd0);
        checkOutput("post_rst_fill",    32'(fill3),    32'd0);
        checkOutput("post_rst_dropped", 32'(dropped3), 32'd1);

        // POST_LEN = 0 instance: trigger without a write freezes at once
        sel0 = 1'b1;
        armRing();
        writeSample(18'd10, 1'b0);
        writeSample(18'd11, 1'b0);
        checkOutput("p0_not_frozen", 32'(frozen0), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        checkOutput("p0_frozen",   32'(frozen0),   32'd1);
        checkOutput("p0_fill",     32'(fill0),     32'd2);
        checkOutput("p0_trig_pos", 32'(trig_pos0), 32'd1);
        readIdx(4'd1, 18'd11);
        readIdx(4'd0, 18'd10);
        idleCycle();
        checkOutput("p0_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
